// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-side branch predictor. A direct-mapped BTB whose
//                entries carry a 2-bit saturating counter gives a same-cycle
//                taken/target prediction for the fetch PC. Execute-stage
//                resolutions train the table, and a registered one-cycle
//                pulse flags each mispredict while a running count tracks
//                how many have occurred.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_f,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int c_ENTRIES = 1 << IDX_W;
    localparam int c_TAG_W   = 32 - IDX_W - 2;

    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WNT = 2'b01;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;

    // BTB storage
    logic               r_valid  [c_ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [c_ENTRIES];
    logic [31:0]        r_target [c_ENTRIES];
    logic [1:0]         r_ctr    [c_ENTRIES];

    logic               r_mispredict;
    logic [CNT_W-1:0]   r_mispred_cnt;

    // Fetch-side lookup
    logic [IDX_W-1:0]   w_f_idx;
    logic [c_TAG_W-1:0] w_f_tag;
    logic               w_f_hit;

    // Update-side lookup
    logic [IDX_W-1:0]   w_u_idx;
    logic [c_TAG_W-1:0] w_u_tag;
    logic               w_u_hit;
    logic               w_wrong;

    // Byte-offset bits of both PCs never address the table
    logic               w_unused_bits;

    assign w_unused_bits = ^{pc_f[1:0], upd_pc[1:0]};

    assign w_f_idx = pc_f[IDX_W+1:2];
    assign w_f_tag = pc_f[31:IDX_W+2];
    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[31:IDX_W+2];

    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    // A target mismatch only matters when both the prediction and the outcome were taken
    assign w_wrong = (upd_pred_taken != upd_taken) ||
                     (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

    // Zero-latency prediction from registered table state; no bypass of a same-cycle update
    always_comb begin
        w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
        pred_target = pred_taken ? r_target[w_f_idx] : (pc_f + 32'd4);
    end

    // Train the BTB entry selected by the resolved PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_WNT;
            end
        end else if (upd_valid) begin
            if (w_u_hit) begin
                if (upd_taken) begin
                    r_target[w_u_idx] <= upd_target;
                    if (r_ctr[w_u_idx] != c_CTR_ST) begin
                        r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
                    end
                end else if (r_ctr[w_u_idx] != c_CTR_SNT) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Not-taken misses are never allocated
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= upd_target;
                r_ctr[w_u_idx]    <= c_CTR_WT;
            end
        end
    end

    // Registered mispredict pulse and its wrapping event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict  <= 1'b0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= upd_valid && w_wrong;
            if (upd_valid && w_wrong) begin
                r_mispred_cnt <= r_mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed testbench for branch_predictor. The stimulus
//                process queues hand-computed expected outputs for every
//                cycle it drives; an independent monitor samples the DUT on
//                the falling edge and compares against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    typedef struct packed {
        logic        pt;
        logic [31:0] tgt;
        logic        mp;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [15:0] mispred_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    failures;
    logic  stim_done;

    branch_predictor #(
        .IDX_W(4),
        .CNT_W(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_f           (pc_f),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue what the
    // outputs must read at the following falling edge
    task automatic step(input logic rst, input logic [31:0] pc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                        input logic ept, input logic [31:0] etgt,
                        input logic emp, input logic [15:0] ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rst;
        pc_f            = pc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        e.pt  = ept;
        e.tgt = etgt;
        e.mp  = emp;
        e.cnt = ecnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare sampled outputs with the oldest queued expectation
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (pred_taken !== e.pt || pred_target !== e.tgt ||
                mispredict !== e.mp || mispred_cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s: got pt=%0b tgt=%h mp=%0b cnt=%0d, expected pt=%0b tgt=%h mp=%0b cnt=%0d",
                         nm, pred_taken, pred_target, mispredict, mispred_cnt,
                         e.pt, e.tgt, e.mp, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        stim_done       = 1'b0;
        rst_n           = 1'b0;
        pc_f            = 32'h100;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;

        //   rst  pc_f          uv  upd_pc        ut  upd_tgt     upt upd_ptgt    | pt  pred_tgt      mp  cnt
        step(0, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h104,       0, 0, "in_reset");
        step(1, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h104,       0, 0, "reset_pred");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     0, 32'h104,     0, 32'h104,       0, 0, "alloc_same_cycle");
        step(1, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       1, 32'h200,       1, 1, "after_alloc");
        step(1, 32'h100,        1, 32'h100,      0, 32'h104,     1, 32'h200,     1, 32'h200,       0, 1, "nt1");
        step(1, 32'h100,        1, 32'h100,      0, 32'h104,     0, 32'h104,     0, 32'h104,       1, 2, "nt2");
        step(1, 32'h100,        1, 32'h100,      0, 32'h104,     0, 32'h104,     0, 32'h104,       0, 2, "nt3_hold");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     0, 32'h104,     0, 32'h104,       0, 2, "t1_from_00");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     0, 32'h104,     0, 32'h104,       1, 3, "t2_from_01");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     1, 32'h200,     1, 32'h200,       1, 4, "t3_from_10");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     1, 32'h200,     1, 32'h200,       0, 4, "t4_saturate");
        step(1, 32'h100,        1, 32'h100,      0, 32'h104,     1, 32'h200,     1, 32'h200,       0, 4, "nt_from_11");
        step(1, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       1, 32'h200,       1, 5, "after_sat_dec");
        step(1, 32'h100,        1, 32'h100,      1, 32'h280,     1, 32'h200,     1, 32'h200,       0, 5, "target_wrong");
        step(1, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       1, 32'h280,       1, 6, "new_target");
        step(1, 32'h140,        1, 32'h140,      1, 32'h300,     0, 32'h144,     0, 32'h144,       0, 6, "alias_replace");
        step(1, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h104,       1, 7, "alias_old_miss");
        step(1, 32'h140,        0, 32'h0,        0, 32'h0,       0, 32'h0,       1, 32'h300,       0, 7, "alias_new_hit");
        step(1, 32'h140,        1, 32'h140,      0, 32'h144,     1, 32'h300,     1, 32'h300,       0, 7, "same_cycle_old");
        step(1, 32'h140,        0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h144,       1, 8, "same_cycle_new");
        step(1, 32'h204,        1, 32'h204,      0, 32'h208,     0, 32'h208,     0, 32'h208,       0, 8, "miss_not_taken");
        step(1, 32'h204,        0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h208,       0, 8, "no_allocation");
        step(1, 32'hFFFFFFFC,   0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h0,         0, 8, "pc_plus4_wrap");
        step(1, 32'hFFFFFFFC,   1, 32'hFFFFFFFC, 1, 32'h40,      0, 32'h0,       0, 32'h0,         0, 8, "alloc_top_idx");
        step(1, 32'hFFFFFFFC,   0, 32'h0,        0, 32'h0,       0, 32'h0,       1, 32'h40,        1, 9, "top_idx_hit");
        step(1, 32'hFFFFFFFC,   0, 32'hFFFFFFFC, 0, 32'h0,       1, 32'h40,      1, 32'h40,        0, 9, "invalid_upd_a");
        step(1, 32'hFFFFFFFC,   0, 32'hFFFFFFFC, 0, 32'h0,       1, 32'h40,      1, 32'h40,        0, 9, "invalid_upd_b");
        step(0, 32'hFFFFFFFC,   1, 32'hFFFFFFFC, 1, 32'h80,      0, 32'h0,       0, 32'h0,         0, 0, "reset_mid");
        step(1, 32'hFFFFFFFC,   0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h0,         0, 0, "reset_discard");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     0, 32'h104,     0, 32'h104,       0, 0, "realloc");
        step(1, 32'h100,        1, 32'h100,      1, 32'h200,     1, 32'h200,     1, 32'h200,       1, 1, "correct_hit");
        step(1, 32'h100,        0, 32'h0,        0, 32'h0,       0, 32'h0,       1, 32'h200,       0, 1, "no_pulse");

        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        #1;
        stim_done = 1'b1;
    end

    // Final accounting once stimulus has drained
    initial begin
        wait (stim_done);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
